// File: rtl/rect_fill_writer.sv
// -----------------------------------------------------------------------------
// rect_fill_writer
//
// Fills an axis-aligned rectangle in video memory with a single colour.
// A command (x, y, w, h, colour) is accepted in IDLE. The block then writes
// one pixel per clock in raster order (x inner, y outer). It pulses done for
// one cycle and returns to IDLE.
//
// Parameters
//   RESOLUTION    "320x240" (17-bit addresses) or "160x120" (15-bit addresses)
//   COLOUR_WIDTH  bits per pixel
//
// Ports
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   cmd_valid    fill command present
//   cmd_ready    block can accept a command (IDLE and not in reset)
//   cmd_x/cmd_y  top-left corner of the rectangle
//   cmd_w/cmd_h  size in dots; either being 0 means an empty rectangle
//   cmd_colour   fill colour
//   wr_address   video-memory write address, y*XMAX + x
//   wr_colour    video-memory write data
//   wr_en        video-memory write strobe
//   busy         high while filling or signalling completion
//   done         one-cycle pulse after a command completes
//
// Build option
//   RECT_FILL_CLIP_EN  when defined, the rectangle is clipped to the screen.
//                      When undefined, sizes are used as given, and
//                      off-screen pixels wrap within the address width.
// -----------------------------------------------------------------------------
module rect_fill_writer #(
   parameter              RESOLUTION   = "320x240",
   parameter int          COLOUR_WIDTH = 3,
   localparam int         ADDR_W       = (RESOLUTION == "320x240") ? 17 : 15
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [8:0]              cmd_x,
   input  logic [7:0]              cmd_y,
   input  logic [8:0]              cmd_w,
   input  logic [7:0]              cmd_h,
   input  logic [COLOUR_WIDTH-1:0] cmd_colour,
   output logic [ADDR_W-1:0]       wr_address,
   output logic [COLOUR_WIDTH-1:0] wr_colour,
   output logic                    wr_en,
   output logic                    busy,
   output logic                    done
);

   localparam bit                IS_320   = (RESOLUTION == "320x240");
   localparam int                XMAX     = IS_320 ? 320 : 160;
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(XMAX);
`ifdef RECT_FILL_CLIP_EN
   localparam int                YMAX     = IS_320 ? 240 : 120;
`endif

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_next;

   logic [8:0]        w_eff;
   logic [7:0]        h_eff;
   logic              eff_empty;
   logic              accept;
   logic              last_col;
   logic              last_pixel;

   logic [8:0]        col_cnt;
   logic [7:0]        row_cnt;
   logic [8:0]        w_last;
   logic [7:0]        h_last;
   logic [ADDR_W-1:0] row_base;

   // y*XMAX + x built from shifts: 320 = 256 + 64, 160 = 128 + 32.
   // All arithmetic is modulo 2^ADDR_W, so off-screen pixels wrap.
   function automatic logic [ADDR_W-1:0] pixel_addr(input logic [8:0] x,
                                                    input logic [7:0] y);
      logic [ADDR_W-1:0] y_ext;
      logic [ADDR_W-1:0] x_ext;
      y_ext = ADDR_W'(y);
      x_ext = ADDR_W'(x);
      if (IS_320)
         return (y_ext << 8) + (y_ext << 6) + x_ext;
      else
         return (y_ext << 7) + (y_ext << 5) + x_ext;
   endfunction

`ifdef RECT_FILL_CLIP_EN
   function automatic logic [8:0] clip_w(input logic [8:0] x, input logic [8:0] w);
      logic [8:0] room;
      room = 9'(XMAX) - x;
      if (x >= 9'(XMAX))
         return 9'd0;
      return (w < room) ? w : room;
   endfunction

   function automatic logic [7:0] clip_h(input logic [7:0] y, input logic [7:0] h);
      logic [7:0] room;
      room = 8'(YMAX) - y;
      if (y >= 8'(YMAX))
         return 8'd0;
      return (h < room) ? h : room;
   endfunction

   assign w_eff = clip_w(cmd_x, cmd_w);
   assign h_eff = clip_h(cmd_y, cmd_h);
`else
   assign w_eff = cmd_w;
   assign h_eff = cmd_h;
`endif

   assign eff_empty  = (w_eff == 9'd0) || (h_eff == 8'd0);
   // Readiness is gated by reset so that no command slips in on a reset edge.
   assign cmd_ready  = (state == IDLE) && !reset;
   assign accept     = cmd_valid && cmd_ready;
   assign last_col   = (col_cnt == w_last);
   assign last_pixel = last_col && (row_cnt == h_last);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   // State register
   always_ff @(posedge clock) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = eff_empty ? DONE : FILL;
         FILL:    if (last_pixel) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Write datapath: the first pixel is presented straight from the accept
   // edge. Each later edge advances one pixel; a row wrap jumps from the
   // row base by one screen line.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_en      <= 1'b0;
         wr_address <= '0;
         wr_colour  <= '0;
         col_cnt    <= '0;
         row_cnt    <= '0;
         w_last     <= '0;
         h_last     <= '0;
         row_base   <= '0;
      end else begin
         case (state)
            IDLE: begin
               wr_en <= 1'b0;
               if (accept) begin
                  // The last indices are only used in FILL, which an empty
                  // rectangle never enters, so the wrap of 0-1 is harmless.
                  w_last     <= w_eff - 9'd1;
                  h_last     <= h_eff - 8'd1;
                  col_cnt    <= '0;
                  row_cnt    <= '0;
                  row_base   <= pixel_addr(cmd_x, cmd_y);
                  wr_address <= pixel_addr(cmd_x, cmd_y);
                  wr_colour  <= cmd_colour;
                  wr_en      <= !eff_empty;
               end
            end
            FILL: begin
               if (last_pixel) begin
                  wr_en <= 1'b0;
               end else if (last_col) begin
                  col_cnt    <= '0;
                  row_cnt    <= row_cnt + 8'd1;
                  row_base   <= row_base + ROW_STEP;
                  wr_address <= row_base + ROW_STEP;
               end else begin
                  col_cnt    <= col_cnt + 9'd1;
                  wr_address <= wr_address + ADDR_W'(1);
               end
            end
            default: wr_en <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_rect_fill_writer.sv
// Bench for rect_fill_writer. It uses two instances, a 320x240 one (a) and a
// 160x120 one (b), which share the command data lines and reset. Each
// instance has its own cmd_valid. Expected writes and done pulses are pushed
// into a queue per instance, with the cycle they must appear in. A monitor
// pops and compares them on every falling edge.
module tb_rect_fill_writer;

   localparam int CW = 3;
`ifdef RECT_FILL_CLIP_EN
   localparam bit CLIP = 1'b1;
`else
   localparam bit CLIP = 1'b0;
`endif

   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic          valid_a = 1'b0;
   logic          valid_b = 1'b0;
   logic [8:0]    cmd_x   = '0;
   logic [7:0]    cmd_y   = '0;
   logic [8:0]    cmd_w   = '0;
   logic [7:0]    cmd_h   = '0;
   logic [CW-1:0] cmd_colour = '0;

   logic          ready_a, ready_b, en_a, en_b, busy_a, busy_b, done_a, done_b;
   logic [16:0]   addr_a;
   logic [14:0]   addr_b;
   logic [CW-1:0] col_a, col_b;

   rect_fill_writer #(.RESOLUTION("320x240"), .COLOUR_WIDTH(CW)) dut_a (
      .clock(clock), .reset(reset), .cmd_valid(valid_a), .cmd_ready(ready_a),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_colour(cmd_colour), .wr_address(addr_a), .wr_colour(col_a),
      .wr_en(en_a), .busy(busy_a), .done(done_a));

   rect_fill_writer #(.RESOLUTION("160x120"), .COLOUR_WIDTH(CW)) dut_b (
      .clock(clock), .reset(reset), .cmd_valid(valid_b), .cmd_ready(ready_b),
      .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
      .cmd_colour(cmd_colour), .wr_address(addr_b), .wr_colour(col_b),
      .wr_en(en_b), .busy(busy_b), .done(done_b));

   typedef struct {
      bit is_done;
      int cyc;
      int addr;
      int col;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_bad  = 0;
   int   pred_a = 0;
   int   pred_b = 0;

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #400000;
      $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int qsize(input bit sel);
      if (sel) return qb.size();
      return qa.size();
   endfunction

   function automatic exp_t qfront(input bit sel);
      if (sel) return qb[0];
      return qa[0];
   endfunction

   function automatic exp_t qpop(input bit sel);
      if (sel) return qb.pop_front();
      return qa.pop_front();
   endfunction

   // Effective side length of the rectangle on a screen of size lim.
   function automatic int eff_len(input int pos, input int len, input int lim);
      if (!CLIP) return len;
      if (pos >= lim) return 0;
      return (len < lim - pos) ? len : lim - pos;
   endfunction

   // Reference model: the full list of writes, then done, for a command
   // accepted so that its first write shows in cycle a.
   task automatic push_model(input bit sel, input int a, input int x, input int y,
                             input int w, input int h, input int c);
      int   xmax, ymax, aw, we, he;
      exp_t e;
      xmax = sel ? 160 : 320;
      ymax = sel ? 120 : 240;
      aw   = sel ? 15 : 17;
      we   = eff_len(x, w, xmax);
      he   = eff_len(y, h, ymax);
      for (int j = 0; j < he; j++)
         for (int i = 0; i < we; i++) begin
            e.is_done = 1'b0;
            e.cyc     = a + j * we + i;
            e.addr    = ((y + j) * xmax + x + i) % (1 << aw);
            e.col     = c;
            if (sel) qb.push_back(e); else qa.push_back(e);
         end
      e.is_done = 1'b1;
      e.cyc     = a + we * he;
      e.addr    = 0;
      e.col     = 0;
      if (sel) qb.push_back(e); else qa.push_back(e);
      if (sel) pred_b = a + we * he + 1; else pred_a = a + we * he + 1;
   endtask

   task automatic monitor(input bit sel, input bit en, input int addr, input int col,
                          input bit dn, input bit rdy, input bit bsy);
      exp_t  e;
      string p;
      p = sel ? "b" : "a";
      while (qsize(sel) > 0 && qfront(sel).cyc < cyc) begin
         e = qpop(sel);
         check({p, e.is_done ? "_missed_done" : "_missed_write"}, 0, 1);
      end
      if (en) begin
         if (qsize(sel) == 0) check({p, "_unexpected_write"}, 1, 0);
         else begin
            e = qpop(sel);
            check({p, "_write_kind"}, 0, int'(e.is_done));
            check({p, "_write_cycle"}, cyc, e.cyc);
            check({p, "_wr_address"}, addr, e.addr);
            check({p, "_wr_colour"}, col, e.col);
         end
      end
      if (dn) begin
         if (qsize(sel) == 0) check({p, "_unexpected_done"}, 1, 0);
         else begin
            e = qpop(sel);
            check({p, "_done_kind"}, 1, int'(e.is_done));
            check({p, "_done_cycle"}, cyc, e.cyc);
         end
      end
      if (reset) check({p, "_ready_in_reset"}, int'(rdy), 0);
      else       check({p, "_busy_vs_ready"}, int'(bsy), int'(!rdy));
   endtask

   always @(negedge clock) begin
      monitor(1'b0, en_a, int'(addr_a), int'(col_a), done_a, ready_a, busy_a);
      monitor(1'b1, en_b, int'(addr_b), int'(col_b), done_b, ready_b, busy_b);
   end

   task automatic check_idle(input int exp_ready);
      check("idle_wr_en_a", int'(en_a), 0);
      check("idle_done_a", int'(done_a), 0);
      check("idle_busy_a", int'(busy_a), 0);
      check("idle_wr_address_a", int'(addr_a), 0);
      check("idle_wr_colour_a", int'(col_a), 0);
      check("idle_ready_a", int'(ready_a), exp_ready);
      check("idle_wr_en_b", int'(en_b), 0);
      check("idle_busy_b", int'(busy_b), 0);
      check("idle_ready_b", int'(ready_b), exp_ready);
   endtask

   // Called just after a rising edge; returns just after the accepting edge
   // with cmd_valid still high, so back-to-back calls hold it continuously.
   task automatic issue(input bit sel, input int x, input int y, input int w,
                        input int h, input int c);
      int p, r, exp_r;
      bit got;
      cmd_x      = 9'(x);
      cmd_y      = 8'(y);
      cmd_w      = 9'(w);
      cmd_h      = 8'(h);
      cmd_colour = CW'(c);
      valid_a    = !sel;
      valid_b    = sel;
      p = -1; r = 0; exp_r = 0; got = 1'b0;
      for (int k = 0; k < 1000 && !got; k++) begin
         @(negedge clock);
         if (p < 0) p = cyc;
         if ((sel ? ready_b : ready_a) === 1'b1) begin
            got   = 1'b1;
            r     = cyc;
            exp_r = sel ? pred_b : pred_a;
            if (p > exp_r) exp_r = p;
            push_model(sel, cyc + 1, x, y, w, h, c);
         end
         @(posedge clock); #1;
      end
      if (!got) begin
         check("ready_timeout", 0, 1);
         valid_a = 1'b0;
         valid_b = 1'b0;
      end else
         check(sel ? "b_ready_cycle" : "a_ready_cycle", r, exp_r);
   endtask

   task automatic idle(input int n);
      valid_a = 1'b0;
      valid_b = 1'b0;
      repeat (n) begin @(posedge clock); #1; end
   endtask

   initial begin
      int sel, x, y, w, h, c, r_cyc;

      repeat (2) @(posedge clock);
      @(negedge clock);
      check_idle(0);
      @(posedge clock); #1;
      reset  = 1'b0;
      pred_a = cyc;
      pred_b = cyc;

      // Basic 3x2 fill, empty command, and back-to-back 1x1 on the small screen.
      issue(0, 10, 20, 3, 2, 5);      idle(10);
      issue(0, 5, 5, 0, 4, 3);        idle(4);
      issue(1, 159, 119, 1, 1, 6);
      issue(1, 159, 119, 1, 1, 6);    idle(5);
      // Bottom-right corner, clipped or written past the edge by build.
      issue(0, 318, 239, 5, 3, 2);    idle(20);
      issue(1, 500, 250, 4, 2, 7);    idle(12);
      issue(0, 400, 10, 3, 1, 1);     idle(6);

      for (int n = 0; n < 40; n++) begin
         sel = int'($urandom_range(0, 1));
         if (n % 3 == 0) begin
            x = (sel != 0 ? 160 : 320) - int'($urandom_range(0, 6));
            y = (sel != 0 ? 120 : 240) - int'($urandom_range(0, 4));
         end else begin
            x = int'($urandom_range(0, 511));
            y = int'($urandom_range(0, 255));
         end
         w = int'($urandom_range(0, 10));
         h = int'($urandom_range(0, 5));
         c = int'($urandom_range(0, 7));
         issue(sel[0], x, y, w, h, c);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(0, 3)));
      end
      idle(80);

      // Abort a large fill with reset after 50 writes.
      issue(0, 0, 0, 100, 100, 4);
      valid_a = 1'b0;
      repeat (49) begin @(posedge clock); #1; end
      reset = 1'b1;
      r_cyc = cyc;
      while (qa.size() > 0 && qa[$].cyc > r_cyc) void'(qa.pop_back());
      while (qb.size() > 0 && qb[$].cyc > r_cyc) void'(qb.pop_back());
      @(posedge clock); #1;
      reset  = 1'b0;
      pred_a = cyc;
      pred_b = cyc;
      @(negedge clock);
      check_idle(1);
      @(posedge clock); #1;
      idle(5);
      issue(0, 1, 2, 2, 2, 1);        idle(10);

      check("queue_a_empty", qa.size(), 0);
      check("queue_b_empty", qb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rect_fill_writer.md
RECT_FILL_WRITER -- requirements
Module: rect_fill_writer

Interface
REQ-001 SHALL provide parameter RESOLUTION, default "320x240", video-memory geometry ("320x240" or "160x120").
REQ-002 SHALL provide parameter COLOUR_WIDTH, default 3, bits per pixel written to video memory.
REQ-003 SHALL have port clock  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  fill command present.
REQ-006 SHALL have port cmd_ready  output  1  block can accept a command.
REQ-007 SHALL have port cmd_x  input  9  left column of the rectangle.
REQ-008 SHALL have port cmd_y  input  8  top row of the rectangle.
REQ-009 SHALL have port cmd_w  input  9  width in dots; 0 means empty.
REQ-010 SHALL have port cmd_h  input  8  height in dots; 0 means empty.
REQ-011 SHALL have port cmd_colour  input  COLOUR_WIDTH  fill colour.
REQ-012 SHALL have port wr_address  output  17 ("320x240") / 15 ("160x120")  video-memory write address.
REQ-013 SHALL have port wr_colour  output  COLOUR_WIDTH  video-memory write data.
REQ-014 SHALL have port wr_en  output  1  video-memory write strobe.
REQ-015 SHALL have port busy  output  1  high in FILL and DONE states.
REQ-016 SHALL have port done  output  1  one-cycle pulse after a command completes.

Function
REQ-017 SHALL implement a state machine with states IDLE, FILL, DONE.
REQ-018 cmd_ready SHALL be high only in IDLE; a command is accepted on the rising edge with cmd_valid && cmd_ready.
REQ-019 On acceptance, x, y, colour and effective width/height SHALL be registered; later input changes SHALL be ignored.
REQ-020 Accepting a command with effective width or height 0 SHALL go IDLE->DONE with no wr_en.
REQ-021 Otherwise IDLE->FILL; the first wr_en SHALL be asserted in the cycle after acceptance.
REQ-022 In FILL, exactly one pixel SHALL be written per cycle, in raster order (x inner, y outer), with no gaps.
REQ-023 wr_address SHALL equal y*320+x ("320x240") or y*160+x ("160x120"); it SHALL use shift-add only, with no multiplier.
REQ-024 wr_address, wr_colour and wr_en SHALL be registered outputs, aligned in the same cycle.
REQ-025 After the last pixel write, FILL->DONE; done=1 for exactly one cycle in DONE, then DONE->IDLE.
REQ-026 For an effective W×H rectangle accepted at cycle 0: writes SHALL occur in cycles 1..W*H, done in cycle W*H+1, and cmd_ready in cycle W*H+2.
REQ-027 cmd_valid held high continuously SHALL result in back-to-back commands separated only by the DONE and IDLE cycles.
REQ-028 wr_en SHALL be low in IDLE and DONE.

Reset
REQ-029 reset=1 SHALL force state IDLE, wr_en=0, done=0, busy=0, wr_address=0, wr_colour=0 and all counters to 0 on the next edge.
REQ-030 Reset asserted during FILL SHALL abort the command, with no further writes and no done pulse.
REQ-031 cmd_ready SHALL be 0 while reset is high and 1 in the first cycle after reset is released.

Configuration
REQ-032 Macro RECT_FILL_CLIP_EN defined: effective width SHALL be min(w, XMAX-x) and effective height min(h, YMAX-y), where XMAX/YMAX are 320/240 or 160/120; x>=XMAX or y>=YMAX SHALL give effective size 0.
REQ-033 Macro RECT_FILL_CLIP_EN undefined: clip logic SHALL be absent; effective size SHALL equal cmd_w/cmd_h, and off-screen pixels SHALL be written at y*XMAX+x truncated to the address width.

Verification
REQ-034 RES 320x240, cmd (x=10,y=20,w=3,h=2,colour=5) accepted at cycle 0 -> wr_address 6410,6411,6412,6730,6731,6732 in cycles 1-6, wr_colour=5, done in cycle 7, cmd_ready in cycle 8.
REQ-035 Cmd (x=5,y=5,w=0,h=4) -> no wr_en; done in cycle 1; cmd_ready in cycle 2.
REQ-036 RECT_FILL_CLIP_EN defined, cmd (x=318,y=239,w=5,h=3) -> only 76798 and 76799 written; done in cycle 3.
REQ-037 Cmd (x=0,y=0,w=100,h=100), reset pulsed in cycle 50 -> wr_en=0 from cycle 51, no done pulse, cmd_ready=1 after reset is released.
REQ-038 RES 160x120, cmd_valid held with two commands (x=159,y=119,w=1,h=1) -> address 19199 written in cycle 1 and again in cycle 4.
